ms_result_serializer: RTL and testbench
=======================================

# ms_result_serializer

Output-side companion to the single-cycle modular squarer. It accepts one squaring result in redundant form: NUM_ELEMENTS coefficients of BIT_LEN bits each, with coefficient i weighted 2^(WORD_LEN·i). It resolves the carries sequentially, one coefficient per cycle, into canonical binary and streams the 1056-bit result out as 32-bit words over a valid/ready handshake. The block sits between the squarer's result port and the host/PCIe readback path.

## Interface
- NUM_ELEMENTS, 62, number of redundant coefficients
- BIT_LEN, 18, coefficient width
- WORD_LEN, 17, radix exponent (coefficient weight step)
- OUT_WIDTH, 32, output word width
- clk  in  1  single clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  result present on in_ms
- in_ready  out  1  block can capture; high only in IDLE with rst low
- in_ms  in  [BIT_LEN-1:0] x NUM_ELEMENTS  redundant result coefficients
- out_valid  out  1  out_data holds a valid word
- out_ready  in  1  sink accepts word
- out_data  out  OUT_WIDTH  output word, least-significant word first
- out_last  out  1  high with the final (33rd) word
- overflow  out  1  present only with MS_SER_OVERFLOW_EN (see Configuration)

## Operation
- States: IDLE, CONVERT.
  - IDLE -> CONVERT on in_valid & in_ready. This captures all of in_ms into a coefficient register and clears carry, digit index, bit count, and word count.
  - CONVERT -> IDLE when all 63 digits are absorbed, the buffer is empty, and the 33rd word has handshaken.
- Digit step for i = 0..61: sum = ms[i] + carry (19 bits); digit = sum[16:0]; carry = sum[18:17] (at most 2 bits).
- After digit 61, one extra 2-bit digit holding the final carry is absorbed. Total width is 62·17 + 2 = 1056 bits, which is exactly 33 words.
- Bit buffer: 49 bits wide with count cnt. A new digit is written at bit position cnt; existing low bits are never disturbed.
- out_valid = (cnt ≥ 32) in CONVERT. out_data = buffer[31:0].
- A handshake (out_valid & out_ready) shifts the buffer right by 32 and reduces cnt by 32.
- A digit is absorbed in a cycle only if digits remain and (cnt − 32·handshake) ≤ 32. This guarantees cnt never exceeds 49.
- out_last = out_valid & (word count == 32).
- in_valid while busy is ignored; in_ready is low.

## Timing
- Reset values: in_ready = 0 while rst is high, 1 on the cycle after; out_valid = 0, out_last = 0, out_data = 0, overflow = 0, state = IDLE.
- Latency: capture at cycle T; digit 0 is absorbed at T+1, digit 1 at T+2; first out_valid at T+3.
- Steady state: one word roughly every 2 cycles with out_ready held high.
- Full transaction with no backpressure completes in about 66 cycles.
- Backpressure: while out_valid & !out_ready, out_data and out_last hold stable. Absorption continues until the buffer guard blocks it.
- rst mid-transaction: the next cycle returns to IDLE with out_valid = 0, and partial data is discarded.
- Capture and the last-word handshake never coincide, because in_ready is high only in IDLE.

## Configuration
- MS_SER_OVERFLOW_EN defined:
  - Adds port overflow.
  - overflow is set in the cycle the final 2-bit carry digit is absorbed, if that digit is nonzero.
  - It stays high until the next capture or rst.
- Macro undefined: no overflow port and no flag logic. The final carry is still emitted in bits 30..31 of word 32.

## Structure
- Package ms_pkg holds:
  - NUM_ELEMENTS, BIT_LEN, WORD_LEN, OUT_WIDTH
  - NUM_OUT_WORDS = 33, BUF_WIDTH = 49
  - the state enum typedef and a coefficient-array typedef
- Sub-module ms_bit_packer: the variable-width append/pop buffer with cnt, the append guard, and the 32-bit pop. The top module holds the FSM, the coefficient register, and the carry ripple.

## Test plan
- All coefficients 0 -> 33 words of 0x00000000; out_last only on word 32; overflow = 0.
- ms[0] = 0x3FFFF, rest 0 -> word0 = 0x0003FFFF, words 1..32 = 0.
- ms[0] = 0x3FFFF, ms[1] = 0x1FFFF, rest 0 (carry ripple) -> word0 = 0x0001FFFF, word1 = 0x00000004, rest 0.
- ms[61] = 0x3FFFF, rest 0 -> word32 = 0x7FFFE000, words 0..31 = 0; overflow = 1 with the macro defined.
- out_ready held low for 10 cycles while word 5 is presented -> out_data is unchanged all 10 cycles; all 33 words are correct, with no loss or duplication.
- rst asserted for 1 cycle after word 10 -> out_valid = 0 the next cycle and in_ready = 1 after that. A new capture then yields a correct word0 at T+3; an in_valid pulse during the aborted transfer is ignored.

Source files
------------

// File: rtl/ms_pkg.sv
// Shared parameters and types for the modular-squarer result serializer.
package ms_pkg;

    localparam int NUM_ELEMENTS  = 62;
    localparam int BIT_LEN       = 18;
    localparam int WORD_LEN      = 17;
    localparam int OUT_WIDTH     = 32;
    localparam int NUM_OUT_WORDS = 33;
    localparam int BUF_WIDTH     = 49;

    // The final carry digit is only two bits wide; digits 0..61 are WORD_LEN wide.
    localparam int CARRY_LEN  = 2;
    localparam int NUM_DIGITS = NUM_ELEMENTS + 1;

    localparam int CNT_W  = 6;   // holds 0..49
    localparam int IDX_W  = 6;   // holds 0..63
    localparam int WCNT_W = 6;   // holds 0..33

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_CONVERT = 1'b1
    } ms_state_e;

    // Coefficient i sits in slice [i]; weight 2^(WORD_LEN*i).
    typedef logic [NUM_ELEMENTS-1:0][BIT_LEN-1:0] ms_coef_t;

endpackage

// File: rtl/ms_bit_packer.sv
// Variable-width append / fixed 32-bit pop bit buffer.
// Digits are written at bit position cnt, so bits already held are never
// disturbed; a pop shifts the buffer right by one output word.
module ms_bit_packer
    import ms_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 active,
    input  logic                 digit_avail,
    input  logic [WORD_LEN-1:0]  digit,
    input  logic [CNT_W-1:0]     digit_width,
    input  logic                 pop_ready,
    output logic                 absorb,
    output logic                 out_valid,
    output logic [OUT_WIDTH-1:0] out_data
);

    logic [BUF_WIDTH-1:0] bit_buf;
    logic [CNT_W-1:0]     cnt;
    logic                 pop;
    logic [CNT_W-1:0]     cnt_after_pop;
    logic [BUF_WIDTH-1:0] buf_after_pop;
    logic [BUF_WIDTH-1:0] appended;

    // Pop and append decisions; the guard keeps cnt at or below 49.
    always_comb begin
        out_valid     = active && (cnt >= CNT_W'(OUT_WIDTH));
        out_data      = bit_buf[OUT_WIDTH-1:0];
        pop           = out_valid && pop_ready;
        cnt_after_pop = pop ? (cnt - CNT_W'(OUT_WIDTH)) : cnt;
        buf_after_pop = pop ? (bit_buf >> OUT_WIDTH) : bit_buf;
        absorb        = active && digit_avail && (cnt_after_pop <= CNT_W'(OUT_WIDTH));
        appended      = BUF_WIDTH'(digit) << cnt_after_pop;
    end

    // Buffer and fill count update.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            bit_buf <= '0;
            cnt     <= '0;
        end else begin
            bit_buf <= absorb ? (buf_after_pop | appended) : buf_after_pop;
            cnt     <= cnt_after_pop + (absorb ? digit_width : CNT_W'(0));
        end
    end

endmodule

// File: rtl/ms_result_serializer.sv
// Resolves a redundant-form squaring result into canonical binary, one
// coefficient per cycle, and streams it out as 33 x 32-bit words LSW first.
// Optional build macro: MS_SER_OVERFLOW_EN adds the sticky overflow port.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | waiting for a result; in_ready high while rst is low
// ST_CONVERT | rippling carries digit by digit and draining output words
module ms_result_serializer
    import ms_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  ms_coef_t             in_ms,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_last
`ifdef MS_SER_OVERFLOW_EN
    ,
    output logic                 overflow
`endif
);

    ms_state_e           state_q, state_d;
    ms_coef_t            coef_q;
    logic [1:0]          carry_q;
    logic [IDX_W-1:0]    digit_idx_q;
    logic [WCNT_W-1:0]   word_cnt_q;

    logic                capture;
    logic                active;
    logic                digit_avail;
    logic                is_carry_digit;
    logic [BIT_LEN:0]    sum;
    logic [WORD_LEN-1:0] digit;
    logic [CNT_W-1:0]    digit_width;
    logic                absorb;
    logic                hs;
    logic                last_hs;

    // Handshake qualifiers and the current digit from the low coefficient.
    always_comb begin
        in_ready       = (state_q == ST_IDLE) && !rst;
        capture        = in_valid && in_ready;
        active         = (state_q == ST_CONVERT);
        digit_avail    = (digit_idx_q < IDX_W'(NUM_DIGITS));
        is_carry_digit = (digit_idx_q == IDX_W'(NUM_ELEMENTS));
        sum            = {1'b0, coef_q[0]} + {{(BIT_LEN-1){1'b0}}, carry_q};
        digit          = is_carry_digit ? {{(WORD_LEN-CARRY_LEN){1'b0}}, carry_q}
                                        : sum[WORD_LEN-1:0];
        digit_width    = is_carry_digit ? CNT_W'(CARRY_LEN) : CNT_W'(WORD_LEN);
        hs             = out_valid && out_ready;
        last_hs        = hs && (word_cnt_q == WCNT_W'(NUM_OUT_WORDS - 1));
        out_last       = out_valid && (word_cnt_q == WCNT_W'(NUM_OUT_WORDS - 1));
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (capture) state_d = ST_CONVERT;
            ST_CONVERT: if (last_hs && !digit_avail) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Coefficient register shifts down one slot per absorbed digit, so the
    // ripple always works on coef_q[0].
    always_ff @(posedge clk) begin
        if (rst) begin
            coef_q      <= '0;
            carry_q     <= '0;
            digit_idx_q <= '0;
            word_cnt_q  <= '0;
        end else if (capture) begin
            coef_q      <= in_ms;
            carry_q     <= '0;
            digit_idx_q <= '0;
            word_cnt_q  <= '0;
        end else begin
            if (absorb) begin
                coef_q      <= coef_q >> BIT_LEN;
                carry_q     <= is_carry_digit ? 2'b00 : sum[BIT_LEN:WORD_LEN];
                digit_idx_q <= digit_idx_q + IDX_W'(1);
            end
            if (hs) word_cnt_q <= word_cnt_q + WCNT_W'(1);
        end
    end

`ifdef MS_SER_OVERFLOW_EN
    // Sticky flag: the final carry digit was nonzero.
    always_ff @(posedge clk) begin
        if (rst || capture)                            overflow <= 1'b0;
        else if (absorb && is_carry_digit && |carry_q) overflow <= 1'b1;
    end
`endif

    ms_bit_packer u_packer (
        .clk         (clk),
        .rst         (rst),
        .clear       (capture),
        .active      (active),
        .digit_avail (digit_avail),
        .digit       (digit),
        .digit_width (digit_width),
        .pop_ready   (out_ready),
        .absorb      (absorb),
        .out_valid   (out_valid),
        .out_data    (out_data)
    );

endmodule

// File: tb/tb_ms_result_serializer.sv
// Self-checking bench for ms_result_serializer. The reference model forms the
// full integer sum(ms[i] * 2^(17*i)) and slices it into 32-bit words.
module tb_ms_result_serializer;
    import ms_pkg::*;

    localparam int TOT_BITS = NUM_OUT_WORDS * OUT_WIDTH;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    ms_coef_t             in_ms;
    logic                 out_valid;
    logic                 out_ready;
    logic [OUT_WIDTH-1:0] out_data;
    logic                 out_last;
`ifdef MS_SER_OVERFLOW_EN
    logic                 overflow;
`endif

    int n_vec = 0;
    int n_err = 0;

    logic [OUT_WIDTH-1:0] exp_words [NUM_OUT_WORDS];
    logic                 exp_ovf;

    always #5 clk = ~clk;

    ms_result_serializer dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ms     (in_ms),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
`ifdef MS_SER_OVERFLOW_EN
        ,
        .overflow  (overflow)
`endif
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void build_expected(input ms_coef_t ms);
        logic [TOT_BITS-1:0] total;
        total = '0;
        for (int i = 0; i < NUM_ELEMENTS; i++)
            total = total + (TOT_BITS'(ms[i]) << (WORD_LEN * i));
        for (int w = 0; w < NUM_OUT_WORDS; w++)
            exp_words[w] = total[w*OUT_WIDTH +: OUT_WIDTH];
        exp_ovf = |total[TOT_BITS-1:TOT_BITS-2];
    endfunction

    function automatic ms_coef_t rand_coefs();
        ms_coef_t ms;
        for (int i = 0; i < NUM_ELEMENTS; i++)
            ms[i] = BIT_LEN'($urandom_range(0, (1 << BIT_LEN) - 1));
        return ms;
    endfunction

    // Wait for in_ready, present one result, and leave right after capture.
    task automatic start_xfer(input ms_coef_t ms, input string tag);
        int guard;
        guard = 0;
        build_expected(ms);
        @(negedge clk);
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL %s in_ready: got %b want 1", tag, in_ready);
        end
        in_valid = 1'b1;
        in_ms    = ms;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_ms    = rand_coefs();
    endtask

    // mode 0: out_ready high; 1: random out_ready; 2: stall 10 cycles at stall_word
    task automatic run_xfer(input ms_coef_t ms, input int mode, input int stall_word,
                            input string tag);
        int cyc, w, first_valid, stall_cnt;
        logic r, prev_stall, prev_last;
        logic [OUT_WIDTH-1:0] prev_data;
        cyc = 0; w = 0; first_valid = -1; stall_cnt = 0;
        prev_stall = 1'b0; prev_last = 1'b0; prev_data = '0;
        start_xfer(ms, tag);
        while (w < NUM_OUT_WORDS && cyc < 500) begin
            @(negedge clk);
            cyc++;
            if (out_valid && first_valid < 0) first_valid = cyc;
            if (prev_stall) begin
                n_vec++;
                if (out_valid !== 1'b1 || out_data !== prev_data || out_last !== prev_last) begin
                    n_err++;
                    $display("FAIL %s hold word%0d: got v=%b d=%h l=%b want v=1 d=%h l=%b",
                             tag, w, out_valid, out_data, out_last, prev_data, prev_last);
                end
            end
            case (mode)
                0:       r = 1'b1;
                1:       r = ($urandom_range(0, 2) != 0);
                default: begin
                    if (w == stall_word && stall_cnt < 10) begin
                        r = 1'b0;
                        stall_cnt++;
                    end else begin
                        r = 1'b1;
                    end
                end
            endcase
            out_ready = r;
            if (out_valid) begin
                if (r) begin
                    n_vec++;
                    if (out_data !== exp_words[w] || out_last !== (w == NUM_OUT_WORDS - 1)) begin
                        n_err++;
                        $display("FAIL %s word%0d: got d=%h l=%b want d=%h l=%b",
                                 tag, w, out_data, out_last, exp_words[w], (w == NUM_OUT_WORDS - 1));
                    end
                    w++;
                end
                prev_stall = !r;
                prev_data  = out_data;
                prev_last  = out_last;
            end else begin
                prev_stall = 1'b0;
            end
        end
        n_vec++;
        if (w != NUM_OUT_WORDS) begin
            n_err++;
            $display("FAIL %s timeout: got %0d words want %0d", tag, w, NUM_OUT_WORDS);
        end
        if (mode == 0) begin
            n_vec++;
            if (first_valid != 3) begin
                n_err++;
                $display("FAIL %s latency: got %0d want 3", tag, first_valid);
            end
        end
        @(negedge clk);
        out_ready = 1'b0;
        n_vec++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL %s return_idle: got rdy=%b v=%b want rdy=1 v=0", tag, in_ready, out_valid);
        end
`ifdef MS_SER_OVERFLOW_EN
        n_vec++;
        if (overflow !== exp_ovf) begin
            n_err++;
            $display("FAIL %s overflow: got %b want %b", tag, overflow, exp_ovf);
        end
`endif
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1; in_ms = rand_coefs();
        repeat (3) @(negedge clk);
        n_vec++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_last !== 1'b0 || out_data !== '0) begin
            n_err++;
            $display("FAIL reset_values: got rdy=%b v=%b l=%b d=%h want 0 0 0 0",
                     in_ready, out_valid, out_last, out_data);
        end
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        n_vec++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release: got rdy=%b v=%b want rdy=1 v=0", in_ready, out_valid);
        end
    endtask

    task automatic test_directed();
        ms_coef_t ms;
        ms = '0;
        run_xfer(ms, 0, 0, "all_zero");
        ms = '0; ms[0] = 18'h3FFFF;
        run_xfer(ms, 0, 0, "ms0_max");
        ms = '0; ms[0] = 18'h3FFFF; ms[1] = 18'h1FFFF;
        run_xfer(ms, 0, 0, "ripple");
        ms = '0; ms[NUM_ELEMENTS-1] = 18'h3FFFF;
        run_xfer(ms, 0, 0, "top_max");
        n_vec++;
        if (exp_words[NUM_OUT_WORDS-1] !== 32'h7FFFE000 || exp_ovf !== 1'b1) begin
            n_err++;
            $display("FAIL model_top_max: got %h ovf=%b want 7fffe000 ovf=1",
                     exp_words[NUM_OUT_WORDS-1], exp_ovf);
        end
    endtask

    task automatic test_backpressure();
        run_xfer(rand_coefs(), 2, 5, "stall_w5");
    endtask

    task automatic test_random();
        ms_coef_t ms;
        for (int k = 0; k < 4; k++)
            run_xfer(rand_coefs(), 1, 0, "random");
        for (int i = 0; i < NUM_ELEMENTS; i++) ms[i] = 18'h3FFFF;
        run_xfer(ms, 1, 0, "all_max");
        run_xfer(rand_coefs(), 0, 0, "back_to_back");
    endtask

    task automatic test_reset_midstream();
        int cyc, w;
        cyc = 0; w = 0;
        start_xfer(rand_coefs(), "abort");
        out_ready = 1'b1;
        while (w < 11 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            in_valid = 1'b0;
            if (w == 3 && cyc < 12) begin
                n_vec++;
                if (in_ready !== 1'b0) begin
                    n_err++;
                    $display("FAIL abort busy_ready: got %b want 0", in_ready);
                end
                in_valid = 1'b1;
            end
            if (out_valid) begin
                n_vec++;
                if (out_data !== exp_words[w]) begin
                    n_err++;
                    $display("FAIL abort word%0d: got %h want %h", w, out_data, exp_words[w]);
                end
                w++;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        n_vec++;
        if (out_valid !== 1'b0 || out_last !== 1'b0 || in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL abort after_rst: got v=%b l=%b rdy=%b want 0 0 0",
                     out_valid, out_last, in_ready);
        end
        rst = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        n_vec++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL abort idle: got rdy=%b v=%b want rdy=1 v=0", in_ready, out_valid);
        end
        run_xfer(rand_coefs(), 0, 0, "after_abort");
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_ms = '0;
        test_reset();
        test_directed();
        test_backpressure();
        test_random();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
